// File: rtl/render_pkg.sv
// Shared VGA timing constants, tile codes, colour type and tile palette lookup.
package render_pkg;

   // 640x480@60 timing, counted in pixel clocks and lines
   localparam int unsigned H_VIS   = 640;
   localparam int unsigned H_FP    = 16;
   localparam int unsigned H_SYNC  = 96;
   localparam int unsigned H_TOTAL = 800;
   localparam int unsigned V_VIS   = 480;
   localparam int unsigned V_FP    = 10;
   localparam int unsigned V_SYNC  = 2;
   localparam int unsigned V_TOTAL = 525;

   // Tile codes as written by the level module
   localparam logic [7:0] BDR = 8'd0;
   localparam logic [7:0] SKY = 8'd1;
   localparam logic [7:0] BLK = 8'd2;
   localparam logic [7:0] GND = 8'd3;
   localparam logic [7:0] TKN = 8'd4;
   localparam logic [7:0] CK1 = 8'd5;
   localparam logic [7:0] CK2 = 8'd6;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   localparam rgb_t PAL_BDR    = rgb_t'(24'h000000);
   localparam rgb_t PAL_SKY    = rgb_t'(24'h5C94FC);
   localparam rgb_t PAL_BLK    = rgb_t'(24'hC84C0C);
   localparam rgb_t PAL_GND    = rgb_t'(24'h8B4513);
   localparam rgb_t PAL_TKN    = rgb_t'(24'hFFD700);
   localparam rgb_t PAL_CK1    = rgb_t'(24'hFFFFFF);
   localparam rgb_t PAL_CK2    = rgb_t'(24'hFF0000);
   localparam rgb_t PAL_MARIO  = rgb_t'(24'hE00000);
   localparam rgb_t PAL_GOOMBA = rgb_t'(24'hA0522D);

   // Unknown codes fall back to the border colour
   function automatic rgb_t tile_to_rgb(input logic [7:0] code);
      rgb_t c;
      case (code)
         SKY:     c = PAL_SKY;
         BLK:     c = PAL_BLK;
         GND:     c = PAL_GND;
         TKN:     c = PAL_TKN;
         CK1:     c = PAL_CK1;
         CK2:     c = PAL_CK2;
         default: c = PAL_BDR;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Raster counters, per-pixel tile counters, raw syncs and the per-frame snapshot strobe.
module vga_timing_gen
   import render_pkg::*;
#(
   parameter int unsigned H_VISIBLE = H_VIS,
   parameter int unsigned H_FRONT   = H_FP,
   parameter int unsigned H_PULSE   = H_SYNC,
   parameter int unsigned H_PERIOD  = H_TOTAL,
   parameter int unsigned V_VISIBLE = V_VIS,
   parameter int unsigned V_FRONT   = V_FP,
   parameter int unsigned V_PULSE   = V_SYNC,
   parameter int unsigned V_PERIOD  = V_TOTAL,
   parameter int unsigned TILE_PX   = 40
) (
   input  logic       clk,
   input  logic       reset,
   output logic [9:0] h_cnt,
   output logic [9:0] v_cnt,
   output logic [3:0] tile_col,
   output logic [3:0] tile_row,
   output logic       hs_raw,
   output logic       vs_raw,
   output logic       visible,
   output logic       snap
);

   localparam logic [9:0] H_LAST     = 10'(H_PERIOD - 1);
   localparam logic [9:0] V_LAST     = 10'(V_PERIOD - 1);
   localparam logic [9:0] H_VIS_LAST = 10'(H_VISIBLE - 1);
   localparam logic [9:0] V_VIS_LAST = 10'(V_VISIBLE - 1);
   localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FRONT + H_PULSE);
   localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FRONT + V_PULSE);
   localparam logic [5:0] T_LAST     = 6'(TILE_PX - 1);

   logic [5:0] px_in_tile;
   logic [5:0] line_in_tile;

   // Advance raster and tile counters; tile counters hold during blanking
   always_ff @(posedge clk) begin
      if (reset) begin
         h_cnt        <= '0;
         v_cnt        <= '0;
         px_in_tile   <= '0;
         tile_col     <= '0;
         line_in_tile <= '0;
         tile_row     <= '0;
      end else if (h_cnt == H_LAST) begin
         h_cnt      <= '0;
         px_in_tile <= '0;
         tile_col   <= '0;
         if (v_cnt == V_LAST) begin
            v_cnt        <= '0;
            line_in_tile <= '0;
            tile_row     <= '0;
         end else begin
            v_cnt <= v_cnt + 10'd1;
            if (v_cnt < V_VIS_LAST) begin
               if (line_in_tile == T_LAST) begin
                  line_in_tile <= '0;
                  tile_row     <= tile_row + 4'd1;
               end else begin
                  line_in_tile <= line_in_tile + 6'd1;
               end
            end
         end
      end else begin
         h_cnt <= h_cnt + 10'd1;
         if (h_cnt < H_VIS_LAST) begin
            if (px_in_tile == T_LAST) begin
               px_in_tile <= '0;
               tile_col   <= tile_col + 4'd1;
            end else begin
               px_in_tile <= px_in_tile + 6'd1;
            end
         end
      end
   end

   assign hs_raw  = !((h_cnt >= HS_START) && (h_cnt < HS_END));
   assign vs_raw  = !((v_cnt >= VS_START) && (v_cnt < VS_END));
   assign visible = (h_cnt <= H_VIS_LAST) && (v_cnt <= V_VIS_LAST);
   // First cycle of the first blanking line
   assign snap    = (h_cnt == 10'd0) && (v_cnt == 10'(V_VISIBLE));

endmodule

// File: rtl/tile_frame_renderer.sv
// Tile map + sprite renderer: per-frame shadow of level state and a 2-stage colour pipeline.
module tile_frame_renderer
   import render_pkg::*;
#(
   parameter int unsigned CHARACTER_WIDTH = 42,
   parameter int unsigned SCREEN_WIDTH    = H_VIS,
   parameter int unsigned SCREEN_HEIGHT   = V_VIS,
   parameter int unsigned BLOCK_WIDTH     = 40,
   parameter int unsigned H_FRONT         = H_FP,
   parameter int unsigned H_PULSE         = H_SYNC,
   parameter int unsigned H_PERIOD        = H_TOTAL,
   parameter int unsigned V_FRONT         = V_FP,
   parameter int unsigned V_PULSE         = V_SYNC,
   parameter int unsigned V_PERIOD        = V_TOTAL
) (
   input  logic                     vga_clock,
   input  logic                     reset,
   input  logic [11:0][16:0][7:0]   background,
   input  logic signed [31:0]       mario_x,
   input  logic signed [31:0]       mario_y,
   input  logic signed [31:0]       goomba_x,
   input  logic signed [31:0]       goomba_y,
   input  logic signed [31:0]       goomba_2x,
   input  logic signed [31:0]       goomba_2y,
   output logic [7:0]               vga_r,
   output logic [7:0]               vga_g,
   output logic [7:0]               vga_b,
   output logic                     vga_hs,
   output logic                     vga_vs,
   output logic                     vga_blank_n,
   output logic                     vga_sync_n,
   output logic                     frame_start
);

   localparam int          CW       = int'(CHARACTER_WIDTH);
   localparam logic signed [31:0] OFF_SCREEN = 32'sd1000;

   logic [9:0] h_cnt, v_cnt;
   logic [3:0] tile_col, tile_row;
   logic       hs_raw, vs_raw, visible, snap;

   vga_timing_gen #(
      .H_VISIBLE (SCREEN_WIDTH),
      .H_FRONT   (H_FRONT),
      .H_PULSE   (H_PULSE),
      .H_PERIOD  (H_PERIOD),
      .V_VISIBLE (SCREEN_HEIGHT),
      .V_FRONT   (V_FRONT),
      .V_PULSE   (V_PULSE),
      .V_PERIOD  (V_PERIOD),
      .TILE_PX   (BLOCK_WIDTH)
   ) u_timing (
      .clk      (vga_clock),
      .reset    (reset),
      .h_cnt    (h_cnt),
      .v_cnt    (v_cnt),
      .tile_col (tile_col),
      .tile_row (tile_row),
      .hs_raw   (hs_raw),
      .vs_raw   (vs_raw),
      .visible  (visible),
      .snap     (snap)
   );

   logic [11:0][16:0][7:0] bg_q;
   logic signed [31:0]     mario_x_q, mario_y_q, goomba_x_q, goomba_y_q;
   logic signed [31:0]     goomba_2x_q, goomba_2y_q;

   // Capture the level state once per frame so rendering never tears
   always_ff @(posedge vga_clock) begin
      if (reset) begin
         bg_q        <= {(12 * 17){BDR}};
         mario_x_q   <= OFF_SCREEN;
         mario_y_q   <= OFF_SCREEN;
         goomba_x_q  <= OFF_SCREEN;
         goomba_y_q  <= OFF_SCREEN;
         goomba_2x_q <= OFF_SCREEN;
         goomba_2y_q <= OFF_SCREEN;
      end else if (snap) begin
         bg_q        <= background;
         mario_x_q   <= mario_x;
         mario_y_q   <= mario_y;
         goomba_x_q  <= goomba_x;
         goomba_y_q  <= goomba_y;
         goomba_2x_q <= goomba_2x;
         goomba_2y_q <= goomba_2y;
      end
   end

   // Screen top-left maps to the array's bottom-right; column 0 is never shown
   logic [3:0] row_idx;
   logic [4:0] col_idx;
   assign row_idx = 4'd11 - tile_row;
   assign col_idx = 5'd16 - {1'b0, tile_col};

   logic signed [31:0] px_s, py_s;
   assign px_s = $signed({22'd0, h_cnt});
   assign py_s = $signed({22'd0, v_cnt});

   function automatic logic in_box(input logic signed [31:0] px, input logic signed [31:0] py,
                                   input logic signed [31:0] x, input logic signed [31:0] y);
      return (px >= x) && (px < x + CW) && (py >= y) && (py < y + CW);
   endfunction

   logic [7:0] tile_s1;
   logic       hit_m_s1, hit_g_s1, hit_g2_s1, vis_s1, hs_s1, vs_s1;

   // Stage 1: tile lookup, sprite hit tests and raw timing
   always_ff @(posedge vga_clock) begin
      if (reset) begin
         tile_s1   <= BDR;
         hit_m_s1  <= 1'b0;
         hit_g_s1  <= 1'b0;
         hit_g2_s1 <= 1'b0;
         vis_s1    <= 1'b0;
         hs_s1     <= 1'b1;
         vs_s1     <= 1'b1;
      end else begin
         tile_s1   <= bg_q[row_idx][col_idx];
         hit_m_s1  <= in_box(px_s, py_s, mario_x_q, mario_y_q);
         hit_g_s1  <= in_box(px_s, py_s, goomba_x_q, goomba_y_q);
         hit_g2_s1 <= in_box(px_s, py_s, goomba_2x_q, goomba_2y_q);
         vis_s1    <= visible;
         hs_s1     <= hs_raw;
         vs_s1     <= vs_raw;
      end
   end

   rgb_t rgb_q;
   logic hs_q, vs_q, blank_n_q;

   // Stage 2: priority colour select and blanking, syncs kept aligned to colour
   always_ff @(posedge vga_clock) begin
      if (reset) begin
         rgb_q     <= PAL_BDR;
         hs_q      <= 1'b1;
         vs_q      <= 1'b1;
         blank_n_q <= 1'b0;
      end else begin
         hs_q      <= hs_s1;
         vs_q      <= vs_s1;
         blank_n_q <= vis_s1;
         if (!vis_s1)        rgb_q <= PAL_BDR;
         else if (hit_m_s1)  rgb_q <= PAL_MARIO;
         else if (hit_g_s1)  rgb_q <= PAL_GOOMBA;
         else if (hit_g2_s1) rgb_q <= PAL_GOOMBA;
         else                rgb_q <= tile_to_rgb(tile_s1);
      end
   end

   assign vga_r       = rgb_q.r;
   assign vga_g       = rgb_q.g;
   assign vga_b       = rgb_q.b;
   assign vga_hs      = hs_q;
   assign vga_vs      = vs_q;
   assign vga_blank_n = blank_n_q;
   assign vga_sync_n  = 1'b0;
   assign frame_start = snap;

endmodule

// File: tb/tb_tile_frame_renderer.sv
// Directed bench: a scaled-raster instance (64x48, 4px tiles, 5px sprites) for frame-level
// behaviour plus a default 640x480 instance for line timing.
module tb_tile_frame_renderer;

   localparam int HT = 80;
   localparam int FR = 80 * 54;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [11:0][16:0][7:0] bg;
   logic signed [31:0] mx, my, gx, gy, g2x, g2y;

   logic [7:0] s_r, s_g, s_b, f_r, f_g, f_b;
   logic s_hs, s_vs, s_bl, s_sync, s_fs;
   logic f_hs, f_vs, f_bl, f_sync, f_fs;

   always #5 clk = ~clk;

   tile_frame_renderer #(
      .CHARACTER_WIDTH (5),
      .SCREEN_WIDTH    (64),
      .SCREEN_HEIGHT   (48),
      .BLOCK_WIDTH     (4),
      .H_FRONT         (4),
      .H_PULSE         (8),
      .H_PERIOD        (80),
      .V_FRONT         (2),
      .V_PULSE         (2),
      .V_PERIOD        (54)
   ) dut_s (
      .vga_clock (clk), .reset (rst), .background (bg),
      .mario_x (mx), .mario_y (my), .goomba_x (gx), .goomba_y (gy),
      .goomba_2x (g2x), .goomba_2y (g2y),
      .vga_r (s_r), .vga_g (s_g), .vga_b (s_b), .vga_hs (s_hs), .vga_vs (s_vs),
      .vga_blank_n (s_bl), .vga_sync_n (s_sync), .frame_start (s_fs)
   );

   tile_frame_renderer dut_f (
      .vga_clock (clk), .reset (rst), .background (bg),
      .mario_x (mx), .mario_y (my), .goomba_x (gx), .goomba_y (gy),
      .goomba_2x (g2x), .goomba_2y (g2y),
      .vga_r (f_r), .vga_g (f_g), .vga_b (f_b), .vga_hs (f_hs), .vga_vs (f_vs),
      .vga_blank_n (f_bl), .vga_sync_n (f_sync), .frame_start (f_fs)
   );

   // Cycles since the last clock edge that saw reset high
   int t;
   always @(posedge clk) begin
      if (rst) t <= 0;
      else     t <= t + 1;
   end

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      int          tt;
      int          kind;   // 0 scaled pixel, 1 full-size pixel, 2 scaled frame_start
      int          act;
      logic [26:0] exp;
   } vec_t;

   vec_t  vecs[$];
   string names[$];

   task automatic add(input int tt, input int kind, input int act, input logic [23:0] rgb,
                      input logic hs, input logic vs, input logic bl, input string nm);
      vec_t v;
      v.tt   = tt;
      v.kind = kind;
      v.act  = act;
      v.exp  = {rgb, hs, vs, bl};
      vecs.push_back(v);
      names.push_back(nm);
   endtask

   task automatic check(input string nm, input logic [26:0] act, input logic [26:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0d)", nm, act, exp, t);
      end
   endtask

   task automatic goto(input int target);
      if (t > target) begin
         n_checks++;
         n_fail++;
         $display("FAIL schedule: at t=%0d, required t=%0d", t, target);
      end
      while (t < target) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Output time of scaled pixel (h,v) in frame fr; full-size pixel in frame 0
   function automatic int pt(input int fr, input int h, input int v);
      return fr * FR + v * HT + h + 2;
   endfunction
   function automatic int ptf(input int h, input int v);
      return v * 800 + h + 2;
   endfunction

   logic [26:0] s_out, f_out;
   assign s_out = {s_r, s_g, s_b, s_hs, s_vs, s_bl};
   assign f_out = {f_r, f_g, f_b, f_hs, f_vs, f_bl};

   localparam logic [23:0] C_BDR = 24'h000000;
   localparam logic [23:0] C_SKY = 24'h5C94FC;
   localparam logic [23:0] C_GND = 24'h8B4513;
   localparam logic [23:0] C_TKN = 24'hFFD700;
   localparam logic [23:0] C_MAR = 24'hE00000;
   localparam logic [23:0] C_GMB = 24'hA0522D;

   initial begin
      for (int y = 0; y < 12; y++)
         for (int x = 0; x < 17; x++)
            bg[y][x] = 8'd1;
      bg[11][16] = 8'd3;
      mx = 1000; my = 1000; gx = 1000; gy = 1000; g2x = 1000; g2y = 1000;

      // Frame 0: snapshot still holds border tiles, timing checks
      add(1,             0, 0, C_BDR, 1, 1, 0, "pre_first_vis");
      add(1,             1, 0, C_BDR, 1, 1, 0, "full_pre_first_vis");
      add(pt(0, 0, 0),   0, 0, C_BDR, 1, 1, 1, "first_vis_bdr");
      add(ptf(0, 0),     1, 0, C_BDR, 1, 1, 1, "full_first_vis_bdr");
      add(pt(0, 63, 0),  0, 0, C_BDR, 1, 1, 1, "last_vis_col");
      add(pt(0, 64, 0),  0, 0, C_BDR, 1, 1, 0, "first_blank_col");
      add(pt(0, 67, 0),  0, 0, C_BDR, 1, 1, 0, "hs_before");
      add(pt(0, 68, 0),  0, 0, C_BDR, 0, 1, 0, "hs_first");
      add(pt(0, 75, 0),  0, 0, C_BDR, 0, 1, 0, "hs_last");
      add(pt(0, 76, 0),  0, 0, C_BDR, 1, 1, 0, "hs_after");
      add(pt(0, 79, 0),  0, 0, C_BDR, 1, 1, 0, "line_end");
      add(pt(0, 0, 1),   0, 0, C_BDR, 1, 1, 1, "line_period");
      add(ptf(639, 0),   1, 0, C_BDR, 1, 1, 1, "full_last_vis");
      add(ptf(640, 0),   1, 0, C_BDR, 1, 1, 0, "full_first_blank");
      add(ptf(655, 0),   1, 0, C_BDR, 1, 1, 0, "full_hs_before");
      add(ptf(656, 0),   1, 0, C_BDR, 0, 1, 0, "full_hs_first");
      add(ptf(751, 0),   1, 0, C_BDR, 0, 1, 0, "full_hs_last");
      add(ptf(752, 0),   1, 0, C_BDR, 1, 1, 0, "full_hs_after");
      add(ptf(799, 0),   1, 0, C_BDR, 1, 1, 0, "full_line_end");
      add(ptf(0, 1),     1, 0, C_BDR, 1, 1, 1, "full_line_period");
      add(48 * HT - 1,   2, 0, '0, 0, 0, 0, "fs_before");
      add(48 * HT,       2, 0, '0, 0, 0, 1, "fs_pulse");
      add(48 * HT + 1,   2, 0, '0, 0, 0, 0, "fs_after");
      add(pt(0, 0, 49),  0, 0, C_BDR, 1, 1, 0, "vs_before");
      add(pt(0, 0, 50),  0, 0, C_BDR, 1, 0, 0, "vs_first");
      add(pt(0, 79, 51), 0, 0, C_BDR, 1, 0, 0, "vs_last");
      add(pt(0, 0, 52),  0, 0, C_BDR, 1, 1, 0, "vs_after");
      // Frame 1: new map visible, sprites written mid-frame
      add(pt(1, 0, 0),   0, 0, C_GND, 1, 1, 1, "gnd_origin");
      add(pt(1, 4, 0),   0, 0, C_SKY, 1, 1, 1, "sky_col1");
      add(pt(1, 3, 3),   0, 0, C_GND, 1, 1, 1, "gnd_corner");
      add(pt(1, 0, 4),   0, 0, C_SKY, 1, 1, 1, "sky_row1");
      add(pt(1, 13, 22), 0, 1, C_SKY, 1, 1, 1, "no_sprite_yet");
      // Frame 2: sprites drawn; map edits made mid-frame
      add(pt(2, 0, 1),   0, 2, C_GND, 1, 1, 1, "gnd_f2");
      add(pt(2, 4, 2),   0, 0, C_SKY, 1, 1, 1, "tkn_not_yet");
      add(pt(2, 9, 20),  0, 0, C_SKY, 1, 1, 1, "left_of_mario");
      add(pt(2, 14, 21), 0, 0, C_MAR, 1, 1, 1, "mario_last_col");
      add(pt(2, 15, 21), 0, 0, C_GMB, 1, 1, 1, "goomba_past_mario");
      add(pt(2, 13, 22), 0, 0, C_MAR, 1, 1, 1, "mario_over_goomba");
      add(pt(2, 61, 30), 0, 0, C_SKY, 1, 1, 1, "left_of_goomba2");
      add(pt(2, 62, 30), 0, 0, C_GMB, 1, 1, 1, "goomba2");
      add(pt(2, 64, 30), 0, 0, C_BDR, 1, 1, 0, "sprite_in_blank");
      add(2 * FR + 48 * HT, 2, 0, '0, 0, 0, 1, "fs_frame2");
      // Frame 3: map edits and moved mario visible
      add(pt(3, 4, 2),   0, 0, C_TKN, 1, 1, 1, "tkn_shown");
      add(pt(3, 0, 5),   0, 0, C_BDR, 1, 1, 1, "unknown_code");
      add(pt(3, 14, 21), 0, 0, C_GMB, 1, 1, 1, "goomba_after_move");
      add(pt(3, 0, 40),  0, 0, C_MAR, 1, 1, 1, "neg_x_col0");
      add(pt(3, 2, 40),  0, 0, C_MAR, 1, 1, 1, "neg_x_col2");
      add(pt(3, 3, 40),  0, 0, C_SKY, 1, 1, 1, "neg_x_col3");
      add(pt(3, 63, 40), 0, 0, C_SKY, 1, 1, 1, "no_wrap_right");

      // Reset held for 3 edges
      repeat (3) @(posedge clk);
      #1;
      check("reset_state", {s_out, s_sync, s_fs}, {C_BDR, 3'b110, 2'b00});
      check("full_reset_state", {f_out, f_sync, f_fs}, {C_BDR, 3'b110, 2'b00});
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         goto(vecs[i].tt);
         case (vecs[i].kind)
            0:       check(names[i], s_out, vecs[i].exp);
            1:       check(names[i], f_out, vecs[i].exp);
            default: check(names[i], {26'd0, s_fs}, {26'd0, vecs[i].exp[0]});
         endcase
         if (vecs[i].act == 1) begin
            mx = 10; my = 20; gx = 12; gy = 21; g2x = 62; g2y = 30;
         end else if (vecs[i].act == 2) begin
            bg[11][15] = 8'd4;
            bg[10][16] = 8'd7;
            mx = -2; my = 40;
         end
      end

      // One-cycle reset mid-line at scaled (30,5) of frame 4
      goto(4 * FR + 5 * HT + 30);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("midline_reset_state", {s_out, s_fs}, {C_BDR, 3'b110, 1'b0});
      check("full_midline_reset_state", f_out, {C_BDR, 3'b110});
      goto(1);
      check("post_reset_no_stray", s_out, {C_BDR, 3'b110});
      goto(2);
      check("post_reset_bdr_origin", s_out, {C_BDR, 3'b111});
      check("full_post_reset_bdr", f_out, {C_BDR, 3'b111});
      goto(6);
      check("post_reset_bdr_col1", s_out, {C_BDR, 3'b111});

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
